// File: rtl/parity_updown_counter_if.sv
// Control and status bundle for parity_updown_counter: sequencing inputs, count and
// terminal-count outputs.
interface parity_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (
    output en, dir, mode, load, load_val,
    input  q, tc
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output q, tc
  );
endinterface

// File: rtl/parity_updown_counter.sv
// Up/down counter with binary, odd, even and decimal sequences, parallel load and terminal count.
// Define PARITY_COUNTER_SATURATE_EN to clamp at the range limits instead of wrapping.
module parity_updown_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                    clk,
  input logic                    rst,
  parity_updown_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ModeBin  = 2'b00,
    ModeOdd  = 2'b01,
    ModeEven = 2'b10,
    ModeDec  = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] Max    = '1;
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic [WIDTH-1:0] DecTop = WIDTH'(9);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] bottom, top, step;
  logic             legal;
  mode_e            mode;

  assign mode   = mode_e'(bus.mode);
  assign bus.q  = q_q;
  assign bus.tc = tc_q;

  always_comb begin
    bottom = '0;
    top    = Max;
    step   = One;
    legal  = 1'b1;
    case (mode)
      ModeOdd: begin
        bottom = One;
        step   = WIDTH'(2);
        legal  = q_q[0];
      end
      ModeEven: begin
        top   = Max - One;
        step  = WIDTH'(2);
        legal = ~q_q[0];
      end
      ModeDec: begin
        top   = DecTop;
        legal = (q_q <= DecTop);
      end
      default: ;
    endcase
  end

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (bus.load) begin
      q_d = bus.load_val;
      if (mode == ModeOdd) begin
        q_d[0] = 1'b1;
      end else if (mode == ModeEven) begin
        q_d[0] = 1'b0;
      end
    end else if (bus.en) begin
      if (!legal) begin
        // Off-range value: a single step realigns onto the current sequence.
        if (mode == ModeDec) begin
          q_d = bus.dir ? '0 : DecTop;
        end else if (bus.dir) begin
          q_d = q_q + One;
`ifdef PARITY_COUNTER_SATURATE_EN
          if (q_q == Max) q_d = Max - One;
`else
          tc_d = (q_q == Max);
`endif
        end else begin
          q_d = q_q - One;
`ifdef PARITY_COUNTER_SATURATE_EN
          if (q_q == '0) q_d = One;
`else
          tc_d = (q_q == '0);
`endif
        end
      end else if (bus.dir) begin
        if (q_q == top) begin
`ifdef PARITY_COUNTER_SATURATE_EN
          q_d = top;
`else
          q_d = bottom;
`endif
          tc_d = 1'b1;
        end else begin
          q_d = q_q + step;
        end
      end else begin
        if (q_q == bottom) begin
`ifdef PARITY_COUNTER_SATURATE_EN
          q_d = bottom;
`else
          q_d = top;
`endif
          tc_d = 1'b1;
        end else begin
          q_d = q_q - step;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q  <= RST_VAL;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

endmodule

// File: doc/parity_updown_counter.md
Name: parity_updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit odd up/down T-flip-flop counter.
- Generalised in width and adds run-time selectable sequence modes (binary, odd, even, decimal), count enable, synchronous parallel load and a terminal-count pulse.
- Used as the standard sequence generator for lab datapaths and display drivers.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 4 (decimal mode needs 4 bits).
- RST_VAL, 0, value loaded into q on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  count enable; advance one step per rising edge when high
- dir  input  1  count direction: 1 = up, 0 = down
- mode  input  2  sequence: 00 binary, 01 odd, 10 even, 11 decimal
- load  input  1  synchronous parallel load, priority over en
- load_val  input  WIDTH  value for load
- q  output  WIDTH  registered count
- tc  output  1  registered terminal-count/wrap pulse

Behaviour:
- Reset: asynchronous, active-high. While rst=1: q=RST_VAL and tc=0, independent of clk. The first count step happens on the first rising edge after rst falls.
- Priority at each rising edge: rst > load > en. With en=0 and load=0, q holds and tc=0.
- Load:
  - Binary mode: q=load_val.
  - Odd mode: q=load_val with LSB forced to 1.
  - Even mode: q=load_val with LSB forced to 0.
  - Decimal mode: q=load_val unmodified.
  - tc=0 on any load cycle.
- Sequence ranges (MAX = 2^WIDTH-1):
  - Binary: 0..MAX, step 1.
  - Odd: 1..MAX, step 2.
  - Even: 0..MAX-1, step 2.
  - Decimal: 0..9, step 1.
- Wrap (en=1, in-range q):
  - Up past the top of the range goes to the bottom of the range; down past the bottom goes to the top.
  - tc=1 for exactly the cycle in which q holds the wrapped value; otherwise tc=0.
- Alignment: when q is not a legal member of the current mode's range (mode changed mid-count, or reset value), the next enabled step aligns q.
  - Odd/even mismatch: up gives q+1, down gives q-1, both modulo 2^WIDTH.
    - Example: odd mode, down from 0 gives MAX, with tc=1 because the step crossed zero.
    - Example: even mode, up from MAX gives 0, with tc=1.
    - Any other alignment step gives tc=0.
  - Decimal mode with q>9: up gives 0, down gives 9, tc=0.
- Changes to dir or mode take effect on the next rising edge. There is no pipeline; each step has one-cycle latency.
- All arithmetic is modulo 2^WIDTH. There is no combinational path from inputs to q or tc.

Optional Feature:
- Macro: PARITY_COUNTER_SATURATE_EN.
- Defined: no wrap.
  - An enabled step that would leave the range holds q at the range limit (top going up, bottom going down).
  - tc=1 for every cycle in which a step was attempted while q was at that limit.
  - Alignment steps that would cross zero saturate instead: odd-down from 0 gives 1; even-up from MAX gives MAX-1.
- Undefined: wrap behaviour as specified above.

Test Plan (WIDTH=4, RST_VAL=0):
- Reset: assert rst between clock edges while q=7 -> q=0 and tc=0 immediately, before the next edge; q stays 0 until rst falls.
- Odd mode, en=1, dir=0 from reset -> q: 15(tc=1), 13, 11, 9, 7, 5, 3, 1, 15(tc=1). Then set dir=1 -> 1(tc=1), 3, ...
- Even mode, dir=1 -> q: 0, 2, 4, ..., 14, 0(tc=1). Then load=1 with load_val=7 -> q=6, tc=0. Then load=1 and en=1 together with load_val=9 -> q=8 (load wins).
- Decimal mode: load 12, then up -> 0 (tc=0), 1, ..., 9, 0(tc=1). Then load 12, then down -> 9 (tc=0).
- Binary mode at q=5: toggle en low for 3 cycles -> q holds 5 with tc=0. Switch mode to odd mid-count with dir=1 -> 5 is already legal -> 7, 9.
- With PARITY_COUNTER_SATURATE_EN defined: binary mode, up from 13 -> 14, 15, 15(tc=1), 15(tc=1). Then dir=0 -> 14 (tc=0).
